// File: rtl/fir_filter_seq.sv
// Time-multiplexed FIR filter: one signed MAC walks NTAPS taps per sample, then the
// rounded, shifted and saturated result is offered on a valid/ready output port.
module fir_filter_seq #(
  parameter  int DATA_W    = 16,
  parameter  int COEF_W    = 16,
  parameter  int NTAPS     = 10,
  parameter  int OUT_W     = 16,
  parameter  int SHIFT     = 0,
  parameter  int COEF_INIT = 1,
  localparam int ADDR_W    = $clog2(NTAPS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_sat,
  input  logic              coef_we,
  input  logic [ADDR_W-1:0] coef_addr,
  input  logic [COEF_W-1:0] coef_data
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + $clog2(NTAPS);
  localparam int RND_W  = ACC_W + 1;

  localparam logic signed [RND_W-1:0] RND_ADD =
    (SHIFT > 0) ? (RND_W'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [RND_W-1:0] OUT_MAX =
    {{(RND_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [RND_W-1:0] OUT_MIN =
    {{(RND_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};
  localparam logic [ADDR_W:0]   ADDR_LIM = (ADDR_W + 1)'(NTAPS);
  localparam logic [ADDR_W-1:0] K_LAST   = ADDR_W'(NTAPS - 1);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are both
  // high. in_ready is high only in IDLE; out_valid stays high with out_data/out_sat
  // frozen until the edge that sees out_ready.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic signed [DATA_W-1:0] dl_q   [NTAPS];
  logic signed [DATA_W-1:0] dl_d   [NTAPS];
  logic signed [COEF_W-1:0] coef_q [NTAPS];
  logic signed [COEF_W-1:0] coef_d [NTAPS];
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [ADDR_W-1:0]        k_q, k_d;
  logic                     out_valid_q, out_valid_d;
  logic [OUT_W-1:0]         out_data_q, out_data_d;
  logic                     out_sat_q, out_sat_d;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [RND_W-1:0]  rnd;
  logic signed [RND_W-1:0]  res;
  logic [OUT_W-1:0]         sat_data;
  logic                     sat_flag;

  // The datapath always computes the final value of the current tap; it is only
  // committed to the output registers on the last tap.
  always_comb begin
    prod    = coef_q[k_q] * dl_q[k_q];
    acc_sum = acc_q + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    rnd     = {acc_sum[ACC_W-1], acc_sum} + RND_ADD;
    res     = rnd >>> SHIFT;
    if (res > OUT_MAX) begin
      sat_data = OUT_MAX[OUT_W-1:0];
      sat_flag = 1'b1;
    end else if (res < OUT_MIN) begin
      sat_data = OUT_MIN[OUT_W-1:0];
      sat_flag = 1'b1;
    end else begin
      sat_data = res[OUT_W-1:0];
      sat_flag = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    dl_d        = dl_q;
    coef_d      = coef_q;
    acc_d       = acc_q;
    k_d         = k_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    case (state_q)
      IDLE: begin
        // A write in the accept cycle lands before the MAC reads coef_q.
        if (coef_we && ({1'b0, coef_addr} < ADDR_LIM)) begin
          coef_d[coef_addr] = coef_data;
        end
        if (in_valid) begin
          for (int i = NTAPS - 1; i > 0; i--) begin
            dl_d[i] = dl_q[i-1];
          end
          dl_d[0] = in_data;
          acc_d   = '0;
          k_d     = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_sum;
        k_d   = k_q + ADDR_W'(1);
        if (k_q == K_LAST) begin
          out_data_d  = sat_data;
          out_sat_d   = sat_flag;
          out_valid_d = 1'b1;
          k_d         = '0;
          state_d     = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        dl_q[i]   <= '0;
        coef_q[i] <= COEF_W'(COEF_INIT);
      end
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      dl_q        <= dl_d;
      coef_q      <= coef_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_fir_filter_seq.sv
// Bench for fir_filter_seq: directed scenarios plus random traffic, scored against a
// sum-of-products reference model kept as plain arrays of history and coefficients.
module tb_fir_filter_seq;

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int NTAPS  = 10;
  localparam int OUT_W  = 16;
  localparam int ADDR_W = $clog2(NTAPS);

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic              out_sat;
  logic              coef_we;
  logic [ADDR_W-1:0] coef_addr;
  logic [COEF_W-1:0] coef_data;

  logic              reset2;
  logic              in2_valid;
  logic              in2_ready;
  logic [DATA_W-1:0] in2_data;
  logic              out2_valid;
  logic              out2_ready;
  logic [OUT_W-1:0]  out2_data;
  logic              out2_sat;
  logic              coef2_we;
  logic [ADDR_W-1:0] coef2_addr;
  logic [COEF_W-1:0] coef2_data;

  fir_filter_seq #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .NTAPS(NTAPS), .OUT_W(OUT_W), .SHIFT(0), .COEF_INIT(1)
  ) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data)
  );

  fir_filter_seq #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .NTAPS(NTAPS), .OUT_W(OUT_W), .SHIFT(2), .COEF_INIT(1)
  ) u_shift (
    .clk(clk), .reset(reset2),
    .in_valid(in2_valid), .in_ready(in2_ready), .in_data(in2_data),
    .out_valid(out2_valid), .out_ready(out2_ready), .out_data(out2_data), .out_sat(out2_sat),
    .coef_we(coef2_we), .coef_addr(coef2_addr), .coef_data(coef2_data)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [OUT_W:0] exp_q[$];
  logic [OUT_W:0] exp2_q[$];
  int             lat_q[$];

  logic signed [DATA_W-1:0] m_hist [NTAPS];
  logic signed [COEF_W-1:0] m_coef [NTAPS];
  logic                     prev_ov;

  task automatic check(input string name, input logic ok, input longint got, input longint want);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Round half up by 2^sh, then clamp to the signed output range.
  function automatic logic [OUT_W:0] ref_out(input longint acc, input int sh);
    longint r;
    longint hi;
    longint lo;
    logic   sat;
    if (sh > 0) r = (acc + (longint'(1) <<< (sh - 1))) >>> sh;
    else        r = acc;
    hi  = (longint'(1) <<< (OUT_W - 1)) - 1;
    lo  = -hi - 1;
    sat = 1'b0;
    if (r > hi) begin r = hi; sat = 1'b1; end
    if (r < lo) begin r = lo; sat = 1'b1; end
    return {sat, r[OUT_W-1:0]};
  endfunction

  // Reference model and output monitor for the main instance.
  always @(negedge clk) begin
    longint         acc;
    int             t;
    logic [OUT_W:0] e;
    if (reset) begin
      exp_q.delete();
      lat_q.delete();
      prev_ov = 1'b0;
      for (int k = 0; k < NTAPS; k++) begin
        m_hist[k] = '0;
        m_coef[k] = COEF_W'(1);
      end
    end else begin
      if (coef_we && in_ready && (int'(coef_addr) < NTAPS)) m_coef[coef_addr] = coef_data;
      if (in_valid && in_ready) begin
        for (int k = NTAPS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = in_data;
        acc = 0;
        for (int k = 0; k < NTAPS; k++) acc += longint'(m_coef[k]) * longint'(m_hist[k]);
        exp_q.push_back(ref_out(acc, 0));
        lat_q.push_back(cyc);
      end
      if (out_valid && !prev_ov) begin
        if (lat_q.size() == 0) begin
          check("unexpected_out_valid", 1'b0, 1, 0);
        end else begin
          t = lat_q.pop_front();
          check("latency", (cyc - t) == NTAPS + 1, cyc - t, NTAPS + 1);
        end
      end
      if (out_valid && out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL out_extra: got data=%0d sat=%0b, expected no output", $signed(out_data), out_sat);
        end else begin
          e = exp_q.pop_front();
          if ({out_sat, out_data} !== e) begin
            n_err++;
            $display("FAIL out_data: got data=%0d sat=%0b, expected data=%0d sat=%0b (cycle %0d)",
                     $signed(out_data), out_sat, $signed(e[OUT_W-1:0]), e[OUT_W], cyc);
          end
        end
      end
      prev_ov = out_valid;
    end
  end

  // Output monitor for the SHIFT=2 instance.
  always @(negedge clk) begin
    logic [OUT_W:0] e;
    if (!reset2 && out2_valid && out2_ready) begin
      n_vec++;
      if (exp2_q.size() == 0) begin
        n_err++;
        $display("FAIL shift_extra: got data=%0d, expected no output", $signed(out2_data));
      end else begin
        e = exp2_q.pop_front();
        if ({out2_sat, out2_data} !== e) begin
          n_err++;
          $display("FAIL shift_out: got data=%0d sat=%0b, expected data=%0d sat=%0b",
                   $signed(out2_data), out2_sat, $signed(e[OUT_W-1:0]), e[OUT_W]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DATA_W-1:0] d);
    logic acc_ok;
    int   t;
    in_valid = 1'b1;
    in_data  = d;
    t = 0;
    acc_ok = 1'b0;
    while (!acc_ok && t < 200) begin
      @(negedge clk);
      acc_ok = in_ready;
      step();
      t++;
    end
    in_valid = 1'b0;
    if (!acc_ok) check("accept_timeout", 1'b0, t, 200);
  endtask

  task automatic coef_write(input int addr, input logic [COEF_W-1:0] d);
    coef_we   = 1'b1;
    coef_addr = ADDR_W'(addr);
    coef_data = d;
    step();
    coef_we   = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || !in_ready) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) check("drain_timeout", 1'b0, exp_q.size(), 0);
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [OUT_W-1:0] held_data;
    logic             held_sat;
    int               t;
    int               v;
    int               cv;
    logic signed [DATA_W-1:0] s2_in  [3];
    logic signed [OUT_W-1:0]  s2_out [3];

    reset = 1'b1; reset2 = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    in2_valid = 1'b0; in2_data = '0; out2_ready = 1'b1;
    coef2_we = 1'b0; coef2_addr = '0; coef2_data = '0;

    @(negedge clk);
    check("rst_in_ready", in_ready === 1'b1, in_ready, 1);
    check("rst_out_valid", out_valid === 1'b0, out_valid, 0);
    check("rst_out_data", out_data === '0, out_data, 0);
    check("rst_out_sat", out_sat === 1'b0, out_sat, 0);
    step(); step();
    reset = 1'b0; reset2 = 1'b0;
    step();

    // Moving sum of 1..12, back to back.
    for (int i = 1; i <= 12; i++) send(DATA_W'(i));
    wait_drain();

    // Single-tap gain of 2.
    coef_write(0, 16'd2);
    for (int i = 1; i < NTAPS; i++) coef_write(i, 16'd0);
    send(16'd5);
    send(16'(-7));
    wait_drain();

    // Saturation at both rails.
    for (int i = 0; i < NTAPS; i++) coef_write(i, 16'h7fff);
    repeat (NTAPS) send(16'h7fff);
    repeat (NTAPS) send(16'h8000);
    wait_drain();

    // Back-pressure: output held, input and coef writes ignored.
    for (int i = 0; i < NTAPS; i++) coef_write(i, COEF_W'(i + 1));
    out_ready = 1'b0;
    send(16'd100);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("stall_valid_seen", out_valid === 1'b1, out_valid, 1);
    held_data = out_data;
    held_sat  = out_sat;
    for (int i = 0; i < 5; i++) begin
      step();
      in_valid = 1'b1; in_data = 16'd1234;
      coef_we = 1'b1; coef_addr = '0; coef_data = 16'd999;
      @(negedge clk);
      check("stall_data", out_data === held_data && out_sat === held_sat, out_data, held_data);
      check("stall_valid", out_valid === 1'b1, out_valid, 1);
      check("stall_in_ready", in_ready === 1'b0, in_ready, 0);
    end
    step();
    in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("release_in_ready", in_ready === 1'b1, in_ready, 1);
    wait_drain();

    // Coef writes while busy, and to an out-of-range tap, change nothing.
    send(16'd5);
    step();
    coef_we = 1'b1; coef_addr = ADDR_W'(1); coef_data = 16'd1000;
    step(); step();
    coef_we = 1'b0;
    wait_drain();
    coef_write(NTAPS, 16'd500);
    send(16'd7);
    wait_drain();

    // Reset in the middle of a computation.
    send(16'd9);
    step(); step(); step();
    reset = 1'b1;
    #1;
    check("midrst_out_valid", out_valid === 1'b0, out_valid, 0);
    check("midrst_in_ready", in_ready === 1'b1, in_ready, 1);
    check("midrst_out_data", out_data === '0, out_data, 0);
    step();
    reset = 1'b0;
    step();
    send(16'd4);
    wait_drain();

    // SHIFT=2 instance, fresh history per sample.
    s2_in[0] = 16'sd3;  s2_out[0] = 16'sd1;
    s2_in[1] = -16'sd3; s2_out[1] = -16'sd1;
    s2_in[2] = 16'sd6;  s2_out[2] = 16'sd2;
    for (int i = 0; i < 3; i++) begin
      reset2 = 1'b1;
      step();
      reset2 = 1'b0;
      exp2_q.push_back({1'b0, s2_out[i]});
      in2_valid = 1'b1;
      in2_data  = s2_in[i];
      step();
      in2_valid = 1'b0;
      t = 0;
      while (exp2_q.size() != 0 && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t >= 50) check("shift_timeout", 1'b0, exp2_q.size(), 0);
      step();
    end

    // Random traffic: small values first, then full range with saturation.
    for (int i = 0; i < 1500; i++) begin
      step();
      in_valid = ($urandom_range(0, 2) != 0);
      v = (i < 800) ? (int'($urandom_range(0, 600)) - 300) : int'($urandom());
      in_data = v[DATA_W-1:0];
      coef_we = ($urandom_range(0, 4) == 0);
      coef_addr = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
      cv = (i < 800) ? (int'($urandom_range(0, 100)) - 50) : int'($urandom());
      coef_data = cv[COEF_W-1:0];
      out_ready = ($urandom_range(0, 3) != 0);
    end
    step();
    in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b1;
    wait_drain();

    check("leftover_expected", exp_q.size() == 0, exp_q.size(), 0);
    check("leftover_latency", lat_q.size() == 0, lat_q.size(), 0);
    check("leftover_shift", exp2_q.size() == 0, exp2_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

endmodule
